dadda_mul_arbiter: RTL and testbench
====================================

Name: dadda_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one pipelined 32-bit Dadda multiplier core between NUM_REQ requesters. It registers the operands of the granted requester into the core and tracks each issue with a tag pipeline. It routes each product back to a per-requester one-entry result buffer and holds it there until the requester takes it. It sits between the processing clients and the multiplier core, which is instantiated beside it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand width; product is 2*WIDTH
MUL_LATENCY, 3, register stages inside the core between mul_a/mul_b and mul_p (0 = purely combinational core)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  request i has operands on req_a/req_b slice i
req_ready  output  NUM_REQ  grant; handshake when req_valid[i] && req_ready[i]
req_a  input  NUM_REQ*WIDTH  packed multiplicands, slice i = bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  packed multipliers
mul_a  output  WIDTH  registered operand A to core
mul_b  output  WIDTH  registered operand B to core
mul_valid  output  1  mul_a/mul_b hold a new issue this cycle
mul_p  input  2*WIDTH  core product, valid MUL_LATENCY cycles after the matching mul_valid cycle
rsp_valid  output  NUM_REQ  result buffer i full
rsp_ready  input  NUM_REQ  requester i consumes its result
rsp_product  output  NUM_REQ*2*WIDTH  packed result buffers, slice i = bits [i*2*WIDTH +: 2*WIDTH]
busy  output  1  any requester in BUSY state

Behaviour:
- Per-requester FSM with states IDLE, BUSY and DONE; all requesters are IDLE at reset.
- IDLE -> BUSY on the req handshake.
- BUSY -> DONE at the edge that captures mul_p for that requester.
- DONE -> IDLE on rsp_valid[i] && rsp_ready[i].
- Only one operation is outstanding per requester, so the result buffers never overflow and no backpressure reaches the core.
- Grant rules:
  - req_ready is combinational from req_valid, FSM state and the RR pointer.
  - At most one bit of req_ready is high per cycle.
  - Eligible requesters are those with req_valid[i]=1 and state IDLE.
  - The grant goes to the first eligible requester searching upward from ptr, wrapping at NUM_REQ.
- The RR pointer resets to 0. On a grant to requester g it becomes (g+1) mod NUM_REQ; with no grant it holds.
- A requester in DONE that is consumed in cycle t is IDLE in t+1. It cannot be granted in cycle t itself.
- Issue at grant edge E:
  - mul_a/mul_b load slice g; mul_valid=1 during cycle E+1, otherwise 0.
  - mul_a/mul_b hold their last value when not issuing.
  - Tag {valid, g} enters a shift register of depth MUL_LATENCY+1.
- Capture:
  - When the tail tag is valid, mul_p is written into result buffer g at edge E+1+MUL_LATENCY.
  - rsp_valid[g] rises in cycle E+2+MUL_LATENCY, so latency from handshake to rsp_valid is MUL_LATENCY+2 cycles (5 at default).
- Throughput is one issue per cycle across requesters; products arrive in issue order.
- rsp_product slice i holds its value while in DONE and keeps its last value otherwise.
- Arithmetic is unsigned; the product is the full 2*WIDTH width with no truncation.
- Reset values: req_ready=0, mul_a=0, mul_b=0, mul_valid=0, rsp_valid=0, rsp_product=0, busy=0, ptr=0, all tags invalid.
- Reset mid-operation:
  - In-flight tags are flushed, and products emerging from the core afterward are ignored.
  - Result buffers are cleared.
  - Reset overrides any simultaneous handshake.
- Simultaneous events:
  - A capture for requester i and rsp_ready[i] in the same cycle is impossible, because the state is BUSY, not DONE.
  - A grant and a capture in the same cycle are independent.
- rsp_ready while rsp_valid=0 is ignored; req_valid while not IDLE is ignored (req_ready=0).

Test Plan:
- Single request, default parameters. req 0 with a=7, b=6, pulsed at edge 0 → mul_valid=1 in cycle 1. rsp_valid[0] rises in cycle 5 with product 42, and busy=1 in cycles 1..4.
- Simultaneous requests. All four assert req_valid in cycle 0, with ptr=0 → grants 0,1,2,3 on consecutive cycles. Results appear in the same order on consecutive cycles.
- Fairness. Req 1 and req 3 request continuously and consume immediately, with ptr=2 → grant order 3,1,3,1, and each requester is never granted while BUSY/DONE.
- Hold and backpressure. Hold rsp_ready[2]=0 for 20 cycles → rsp_valid[2] and rsp_product stay stable, and req_ready[2] stays 0. Other requesters still complete.
- Boundary values. a=b=0xFFFFFFFF → product 0xFFFFFFFE00000001. A zero operand gives 0.
- Reset mid-flight. Assert reset 2 cycles after two grants → all outputs return to 0. No rsp_valid appears afterward, and a new request after reset completes normally.

Source files
------------

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter
// Round-robin front end that shares one pipelined multiplier core between
// NUM_REQ clients. Each client has a three-state FSM (IDLE/BUSY/DONE) and a
// one-entry result buffer. A tag pipeline that follows the core latency routes
// every product back to the client that issued it.
module dadda_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]     req_a,
   input  logic [NUM_REQ*WIDTH-1:0]     req_b,
   output logic [WIDTH-1:0]             mul_a,
   output logic [WIDTH-1:0]             mul_b,
   output logic                         mul_valid,
   input  logic [2*WIDTH-1:0]           mul_p,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [NUM_REQ*2*WIDTH-1:0]   rsp_product,
   output logic                         busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // One tag stage sits beside the operand register; the rest match the core depth.
   localparam int TD = MUL_LATENCY + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state     [NUM_REQ];
   state_t              w_state_nxt [NUM_REQ];
   logic [PW-1:0]       r_ptr;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_gnt_any;
   logic [PW-1:0]       w_gnt_idx;
   logic [NUM_REQ-1:0]  w_cap;
   logic [WIDTH-1:0]    r_mul_a;
   logic [WIDTH-1:0]    r_mul_b;
   logic                r_mul_valid;
   logic                r_tag_vld   [TD];
   logic [PW-1:0]       r_tag_id    [TD];
   logic [2*WIDTH-1:0]  r_prod      [NUM_REQ];

   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign mul_valid = r_mul_valid;

   // Round-robin pick: first idle requester at or above r_ptr, then wrap to the bottom
   always_comb begin
      w_grant   = '0;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_gnt_any && !reset && req_valid[i] && (r_state[i] == S_IDLE) &&
             (PW'(i) >= r_ptr)) begin
            w_gnt_any  = 1'b1;
            w_gnt_idx  = PW'(i);
            w_grant[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_gnt_any && !reset && req_valid[i] && (r_state[i] == S_IDLE)) begin
            w_gnt_any  = 1'b1;
            w_gnt_idx  = PW'(i);
            w_grant[i] = 1'b1;
         end
      end
   end

   // Pointer moves just past the most recent grant and holds otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_gnt_any) begin
         r_ptr <= (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
      end
   end

   // Issue stage: latch the granted operands into the core input register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_mul_valid <= 1'b0;
      end else begin
         r_mul_valid <= w_gnt_any;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
               r_mul_a <= req_a[i*WIDTH +: WIDTH];
               r_mul_b <= req_b[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Tag pipeline: stage 0 lines up with mul_a/mul_b, the tail lines up with mul_p
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TD; k++) begin
            r_tag_vld[k] <= 1'b0;
            r_tag_id[k]  <= '0;
         end
      end else begin
         r_tag_vld[0] <= w_gnt_any;
         r_tag_id[0]  <= w_gnt_idx;
         for (int k = 1; k < TD; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag_id[k]  <= r_tag_id[k-1];
         end
      end
   end

   // Decode the tail tag into a one-hot capture strobe
   always_comb begin
      w_cap = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cap[i] = r_tag_vld[TD-1] && (r_tag_id[TD-1] == PW'(i));
      end
   end

   // Capture stage: product lands in the owner's buffer and stays until the next capture
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_prod[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_cap[i]) begin
               r_prod[i] <= mul_p;
            end
         end
      end
   end

   // Per-requester state register
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_state[i] <= S_IDLE;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // Per-requester next state: grant starts work, capture finishes it, consume frees it
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            S_IDLE:  if (w_grant[i])   w_state_nxt[i] = S_BUSY;
            S_BUSY:  if (w_cap[i])     w_state_nxt[i] = S_DONE;
            S_DONE:  if (rsp_ready[i]) w_state_nxt[i] = S_IDLE;
            default:                   w_state_nxt[i] = S_IDLE;
         endcase
      end
   end

   // Outputs decoded from state, grant and result buffers
   always_comb begin
      req_ready   = w_grant;
      rsp_valid   = '0;
      rsp_product = '0;
      busy        = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i]                       = (r_state[i] == S_DONE);
         rsp_product[i*2*WIDTH +: 2*WIDTH] = r_prod[i];
         if (r_state[i] == S_BUSY) begin
            busy = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Testbench for dadda_mul_arbiter with a behavioural 3-stage multiplier core.
module tb_dadda_mul_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     rsp_ready = '0;
   logic [N*W-1:0]   req_a = '0;
   logic [N*W-1:0]   req_b = '0;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     rsp_valid;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic             mul_valid;
   logic [2*W-1:0]   mul_p;
   logic [N*2*W-1:0] rsp_product;
   logic             busy;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // Behavioural core: L register stages after mul_a/mul_b, no reset
   logic [2*W-1:0] core_pipe [L];
   always @(posedge clk) begin
      core_pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
      for (int k = 1; k < L; k++) core_pipe[k] <= core_pipe[k-1];
   end
   assign mul_p = core_pipe[L-1];

   dadda_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_p(mul_p),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_product(rsp_product), .busy(busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push on request handshake, pop when a result buffer fills
   typedef struct {
      int          id;
      logic [63:0] prod;
   } exp_t;
   exp_t        sb_q [$];
   exp_t        mon_e;
   logic [63:0] mon_p;
   logic [N-1:0] prev_rv = '0;

   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && !prev_rv[i]) begin
               if (sb_q.size() == 0) begin
                  chk($sformatf("sb_unexpected_rsp%0d", i), rsp_valid[i], 0);
               end else begin
                  mon_e = sb_q.pop_front();
                  chk("sb_order_id", i, mon_e.id);
                  chk($sformatf("sb_prod%0d", i), rsp_product[i*2*W +: 2*W], mon_e.prod);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               mon_p = {32'b0, req_a[i*W +: W]} * {32'b0, req_b[i*W +: W]};
               sb_q.push_back(exp_t'{id: i, prod: mon_p});
            end
         end
      end
      prev_rv <= rsp_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
      $fatal(1, "watchdog");
   end

   int           gr [$];
   logic [N-1:0] outstanding;
   int           n0;
   int           lat;
   logic [63:0]  hold_exp;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      // Reset state
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mul_valid", mul_valid, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_product_any", |rsp_product, 0);
      chk("rst_busy", busy, 0);

      // Single request 7*6
      req_a[0 +: W] = 32'd7;
      req_b[0 +: W] = 32'd6;
      req_valid = 4'b0001;
      #1 chk("t1_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      #1;
      chk("t1_mul_valid", mul_valid, 1);
      chk("t1_mul_a", mul_a, 7);
      chk("t1_mul_b", mul_b, 6);
      chk("t1_busy_c1", busy, 1);
      for (int c = 2; c <= 4; c++) begin
         tick(); #1;
         chk($sformatf("t1_busy_c%0d", c), busy, 1);
         chk($sformatf("t1_rsp_valid_c%0d", c), rsp_valid, 0);
         chk($sformatf("t1_mul_valid_c%0d", c), mul_valid, 0);
      end
      tick(); #1;
      chk("t1_rsp_valid_c5", rsp_valid, 4'b0001);
      chk("t1_product", rsp_product[0 +: 64], 42);
      chk("t1_busy_c5", busy, 0);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = '0;
      #1;
      chk("t1_rsp_valid_after", rsp_valid, 0);
      chk("t1_product_kept", rsp_product[0 +: 64], 42);

      // Simultaneous requests from ptr=0, with boundary operands
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_a[0*W +: W] = 32'hFFFF_FFFF; req_b[0*W +: W] = 32'hFFFF_FFFF;
      req_a[1*W +: W] = 32'd0;         req_b[1*W +: W] = 32'd12345;
      req_a[2*W +: W] = 32'h0001_0000; req_b[2*W +: W] = 32'h0001_0000;
      req_a[3*W +: W] = $urandom;      req_b[3*W +: W] = $urandom;
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_grant%0d", k), req_ready, 4'b0001 << k);
         tick(); #1;
      end
      chk("t2_no_regrant", req_ready, 0);
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         chk($sformatf("t2_rsp_valid%0d", k), rsp_valid, (1 << (k + 1)) - 1);
      end
      chk("t2_max_product", rsp_product[0*64 +: 64], 64'hFFFF_FFFE_0000_0001);
      chk("t2_zero_product", rsp_product[1*64 +: 64], 0);
      chk("t2_pow_product", rsp_product[2*64 +: 64], 64'h0000_0001_0000_0000);
      rsp_ready = 4'hF;
      tick();
      rsp_ready = '0;
      #1;
      chk("t2_drained", rsp_valid, 0);
      chk("t2_idle", busy, 0);

      // Fairness: move ptr to 2 via one grant to requester 1, then 1 and 3 compete
      rsp_ready = 4'b1010;
      req_a[1*W +: W] = 32'd11; req_b[1*W +: W] = 32'd13;
      req_a[3*W +: W] = 32'd17; req_b[3*W +: W] = 32'd19;
      req_valid = 4'b0010;
      #1 chk("t3_setup_grant", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      repeat (6) tick();
      outstanding = '0;
      req_valid = 4'b1010;
      #1;
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("t3_no_busy_grant_c%0d", c), req_ready & outstanding, 0);
         if (req_ready != '0) begin
            gr.push_back(req_ready[3] ? 3 : (req_ready[1] ? 1 : -1));
            outstanding = outstanding | req_ready;
         end
         outstanding = outstanding & ~(rsp_valid & rsp_ready);
         tick(); #1;
      end
      req_valid = '0;
      chk("t3_enough_grants", gr.size() >= 4, 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t3_order%0d", k), (gr.size() > k) ? gr[k] : -1, (k % 2 == 0) ? 3 : 1);
      end
      repeat (8) tick();
      rsp_ready = '0;
      #1;
      chk("t3_drained", rsp_valid, 0);
      chk("t3_idle", busy, 0);

      // Hold requester 2's result for 20 cycles while requester 0 keeps completing
      req_a[2*W +: W] = 32'hDEAD_BEEF; req_b[2*W +: W] = 32'h0000_1234;
      req_a[0*W +: W] = 32'd1000;      req_b[0*W +: W] = 32'd3;
      hold_exp = 64'hDEAD_BEEF * 64'h1234;
      req_valid = 4'b0100;
      #1 chk("t4_grant2", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      repeat (4) tick();
      #1 chk("t4_rsp2_up", rsp_valid[2], 1);
      req_valid = 4'b0101;
      rsp_ready = 4'b0001;
      n0 = 0;
      #1;
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("t4_hold_valid_c%0d", c), rsp_valid[2], 1);
         chk($sformatf("t4_hold_prod_c%0d", c), rsp_product[2*64 +: 64], hold_exp);
         chk($sformatf("t4_no_grant2_c%0d", c), req_ready[2], 0);
         if (rsp_valid[0] && rsp_ready[0]) n0++;
         tick(); #1;
      end
      chk("t4_req0_progress", n0 >= 2, 1);
      req_valid = '0;
      rsp_ready = 4'b0101;
      repeat (8) tick();
      rsp_ready = '0;
      #1;
      chk("t4_drained", rsp_valid, 0);
      chk("t4_idle", busy, 0);

      // Reset two cycles after two grants
      req_a[0*W +: W] = 32'd99;  req_b[0*W +: W] = 32'd98;
      req_a[1*W +: W] = 32'd77;  req_b[1*W +: W] = 32'd66;
      req_valid = 4'b0011;
      #1 chk("t5_grant_first", req_ready, 4'b0010);
      tick(); #1;
      chk("t5_grant_second", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("t5_req_ready", req_ready, 0);
      chk("t5_mul_valid", mul_valid, 0);
      chk("t5_mul_a", mul_a, 0);
      chk("t5_mul_b", mul_b, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_rsp_product_any", |rsp_product, 0);
      chk("t5_busy", busy, 0);
      for (int c = 0; c < 10; c++) begin
         tick(); #1;
         chk($sformatf("t5_no_ghost_c%0d", c), rsp_valid, 0);
      end
      req_a[2*W +: W] = 32'd123; req_b[2*W +: W] = 32'd456;
      req_valid = 4'b0100;
      #1 chk("t5_post_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      lat = 1;
      while (!rsp_valid[2] && lat < 12) begin
         tick(); #1;
         lat++;
      end
      chk("t5_post_latency", lat, 5);
      chk("t5_post_product", rsp_product[2*64 +: 64], 64'd56088);
      rsp_ready = 4'b0100;
      tick();
      rsp_ready = '0;
      #1;
      chk("t5_post_drained", rsp_valid, 0);
      chk("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
